// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the reg_bank_wb register bank and its debug dump engine.
package reg_bank_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;

    localparam int unsigned         SP_INDEX_DEF       = 29;
    localparam logic [DATA_W-1:0]   SP_RESET_VALUE_DEF = 32'd227;

    typedef enum logic {
        DUMP_IDLE,
        DUMP_SCAN
    } dump_state_e;

endpackage

// File: rtl/reg_bank_if.sv
// Bus bundle between the datapath/debug host (master) and the register bank (slave).
interface reg_bank_if;
    import reg_bank_pkg::*;

    logic                 reg_write;
    logic [REG_IDX_W-1:0] write_reg;
    logic [DATA_W-1:0]    write_data;
    logic [REG_IDX_W-1:0] read_reg_a;
    logic [REG_IDX_W-1:0] read_reg_b;
    logic [DATA_W-1:0]    read_data_a;
    logic [DATA_W-1:0]    read_data_b;
    logic                 dump_req;
    logic                 dump_busy;
    logic                 dump_valid;
    logic [REG_IDX_W-1:0] dump_idx;
    logic [DATA_W-1:0]    dump_data;

    modport master (
        output reg_write, write_reg, write_data, read_reg_a, read_reg_b, dump_req,
        input  read_data_a, read_data_b, dump_busy, dump_valid, dump_idx, dump_data
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg_a, read_reg_b, dump_req,
        output read_data_a, read_data_b, dump_busy, dump_valid, dump_idx, dump_data
    );

endinterface

// File: rtl/reg_dump_fsm.sv
// Dump sequencer: on request, walks register indices 0..31 once, one per cycle.
module reg_dump_fsm
    import reg_bank_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 dump_req_i,
    output logic                 dump_busy_o,
    output logic                 dump_valid_o,
    output logic [REG_IDX_W-1:0] dump_idx_o
);

    localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(REG_COUNT - 1);

    dump_state_e          state_q, state_d;
    logic [REG_IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= DUMP_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dump_busy_o  = 1'b0;
        dump_valid_o = 1'b0;
        dump_idx_o   = '0;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_req_i) begin
                    state_d = DUMP_SCAN;
                    cnt_d   = '0;
                end
            end
            DUMP_SCAN: begin
                dump_busy_o  = 1'b1;
                dump_valid_o = 1'b1;
                dump_idx_o   = cnt_q;
                // Single pass only: the last entry returns to IDLE instead of wrapping.
                if (cnt_q == LAST_IDX) begin
                    state_d = DUMP_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = REG_IDX_W'(cnt_q + REG_IDX_W'(1));
                end
            end
            default: begin
                state_d = DUMP_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/reg_bank_wb.sv
// MIPS general-purpose register bank with write-through read ports.
// Optional debug dump engine is built when REG_BANK_DUMP_EN is defined.
module reg_bank_wb
    import reg_bank_pkg::*;
#(
    parameter int unsigned       SP_INDEX       = SP_INDEX_DEF,
    parameter logic [DATA_W-1:0] SP_RESET_VALUE = SP_RESET_VALUE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    reg_bank_if.slave  bus
);

`ifdef REG_BANK_DUMP_EN
    localparam int unsigned RD_PORTS = 3;
`else
    localparam int unsigned RD_PORTS = 2;
`endif

    logic [DATA_W-1:0]    regs_q  [REG_COUNT];
    logic [REG_IDX_W-1:0] rd_idx  [RD_PORTS];
    logic [DATA_W-1:0]    rd_data [RD_PORTS];
    logic                 wr_en;

    assign wr_en = bus.reg_write && (bus.write_reg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_RESET_VALUE : '0;
            end
        end else if (wr_en) begin
            regs_q[bus.write_reg] <= bus.write_data;
        end
    end

    // Every read port (operand A/B and the dump tap) shares the r0 and bypass rules.
    always_comb begin
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            rd_data[p] = '0;
            if (rd_idx[p] == '0) begin
                rd_data[p] = '0;
            end else if (wr_en && (bus.write_reg == rd_idx[p])) begin
                rd_data[p] = bus.write_data;
            end else begin
                rd_data[p] = regs_q[rd_idx[p]];
            end
        end
    end

    assign rd_idx[0]       = bus.read_reg_a;
    assign rd_idx[1]       = bus.read_reg_b;
    assign bus.read_data_a = rd_data[0];
    assign bus.read_data_b = rd_data[1];

`ifdef REG_BANK_DUMP_EN
    logic                 dump_valid;
    logic [REG_IDX_W-1:0] dump_idx;

    reg_dump_fsm u_dump (
        .clk_i        (clk),
        .reset_i      (reset),
        .dump_req_i   (bus.dump_req),
        .dump_busy_o  (bus.dump_busy),
        .dump_valid_o (dump_valid),
        .dump_idx_o   (dump_idx)
    );

    assign rd_idx[2]      = dump_idx;
    assign bus.dump_valid = dump_valid;
    assign bus.dump_idx   = dump_idx;
    assign bus.dump_data  = dump_valid ? rd_data[2] : '0;
`else
    logic unused_dump_req;

    assign unused_dump_req = bus.dump_req;
    assign bus.dump_busy   = 1'b0;
    assign bus.dump_valid  = 1'b0;
    assign bus.dump_idx    = '0;
    assign bus.dump_data   = '0;
`endif

endmodule

// File: tb/tb_reg_bank_wb.sv
// Self-checking bench for reg_bank_wb: architectural model compared every cycle plus literal checks.
module tb_reg_bank_wb;
    import reg_bank_pkg::*;

    logic clk;
    logic reset;

    reg_bank_if bus ();

    reg_bank_wb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Architectural model: register contents and current dump position (-1 = not dumping).
    logic [31:0] m_regs [32];
    int          m_dpos  = -1;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= (i == 29) ? 32'd227 : 32'd0;
            m_dpos  <= -1;
            m_valid <= 1'b1;
        end else begin
            if (bus.reg_write && bus.write_reg != 5'd0) m_regs[bus.write_reg] <= bus.write_data;
`ifdef REG_BANK_DUMP_EN
            if (m_dpos < 0) begin
                if (bus.dump_req) m_dpos <= 0;
            end else begin
                m_dpos <= (m_dpos == 31) ? -1 : m_dpos + 1;
            end
`endif
        end
    end

    function automatic logic [31:0] exp_rd(input int idx);
        if (idx == 0) return 32'd0;
        if (bus.reg_write && bus.write_reg != 5'd0 && int'(bus.write_reg) == idx) return bus.write_data;
        return m_regs[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (!m_valid) return;
        check("mdl_rd_a", bus.read_data_a, exp_rd(int'(bus.read_reg_a)));
        check("mdl_rd_b", bus.read_data_b, exp_rd(int'(bus.read_reg_b)));
        check("mdl_busy",  32'(bus.dump_busy),  (m_dpos >= 0) ? 32'd1 : 32'd0);
        check("mdl_valid", 32'(bus.dump_valid), (m_dpos >= 0) ? 32'd1 : 32'd0);
        check("mdl_idx",   32'(bus.dump_idx),   (m_dpos >= 0) ? 32'(m_dpos) : 32'd0);
        check("mdl_data",  bus.dump_data,       (m_dpos >= 0) ? exp_rd(m_dpos) : 32'd0);
    endtask

    // One cycle: compare at the falling edge, then advance just past the rising edge.
    task automatic step();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dump_exp(input int k);
        case (k)
            1:       return 32'h0000_0001;
            5:       return 32'h0000_0055;
            29:      return 32'h0000_00E3;
            31:      return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    initial begin
        reset          = 1'b1;
        bus.reg_write  = 1'b0;
        bus.write_reg  = '0;
        bus.write_data = '0;
        bus.read_reg_a = '0;
        bus.read_reg_b = '0;
        bus.dump_req   = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset contents on both ports
        for (int i = 0; i < 32; i++) begin
            bus.read_reg_a = 5'(i);
            bus.read_reg_b = 5'(31 - i);
            #1;
            check("rst_a", bus.read_data_a, (i == 29) ? 32'h0000_00E3 : 32'h0);
            check("rst_b", bus.read_data_b, ((31 - i) == 29) ? 32'h0000_00E3 : 32'h0);
            step();
        end
        check("rst_busy",  32'(bus.dump_busy),  32'd0);
        check("rst_valid", 32'(bus.dump_valid), 32'd0);
        check("rst_idx",   32'(bus.dump_idx),   32'd0);
        check("rst_data",  bus.dump_data,       32'd0);

        // Write-through bypass and stored value
        bus.reg_write = 1'b1; bus.write_reg = 5'd8; bus.write_data = 32'hDEAD_BEEF;
        bus.read_reg_a = 5'd8; bus.read_reg_b = 5'd8;
        #1;
        check("byp_a", bus.read_data_a, 32'hDEAD_BEEF);
        check("byp_b", bus.read_data_b, 32'hDEAD_BEEF);
        step();
        bus.reg_write = 1'b0;
        #1;
        check("stored_a", bus.read_data_a, 32'hDEAD_BEEF);
        step();

        // r0 is hardwired to zero
        bus.reg_write = 1'b1; bus.write_reg = 5'd0; bus.write_data = 32'h0000_1234;
        bus.read_reg_a = 5'd0; bus.read_reg_b = 5'd0;
        #1;
        check("r0_byp", bus.read_data_a, 32'h0);
        step();
        bus.reg_write = 1'b0;
        #1;
        check("r0_after", bus.read_data_b, 32'h0);
        step();

        // Reset wins over a simultaneous write
        reset = 1'b1;
        bus.reg_write = 1'b1; bus.write_reg = 5'd29; bus.write_data = 32'd5;
        bus.read_reg_a = 5'd29; bus.read_reg_b = 5'd8;
        step();
        reset = 1'b0; bus.reg_write = 1'b0;
        #1;
        check("rst_prio_r29", bus.read_data_a, 32'h0000_00E3);
        check("rst_clr_r8",   bus.read_data_b, 32'h0);
        step();

        // Preload r1 and r31, then a full dump
        bus.reg_write = 1'b1; bus.write_reg = 5'd1;  bus.write_data = 32'h1;
        step();
        bus.write_reg = 5'd31; bus.write_data = 32'hFFFF_FFFF;
        step();
        bus.reg_write = 1'b0;
        bus.dump_req  = 1'b1;
        step();
        bus.dump_req  = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 5) begin
                bus.reg_write = 1'b1; bus.write_reg = 5'd5; bus.write_data = 32'h55;
            end
            if (k == 10) bus.dump_req = 1'b1;
            #1;
`ifdef REG_BANK_DUMP_EN
            check("dump_valid", 32'(bus.dump_valid), 32'd1);
            check("dump_busy",  32'(bus.dump_busy),  32'd1);
            check("dump_idx",   32'(bus.dump_idx),   32'(k));
            check("dump_data",  bus.dump_data,       dump_exp(k));
`else
            check("nodump_valid", 32'(bus.dump_valid), 32'd0);
            check("nodump_data",  bus.dump_data,       32'd0);
`endif
            step();
            bus.reg_write = 1'b0;
            bus.dump_req  = 1'b0;
        end
        #1;
        check("dump_end_busy",  32'(bus.dump_busy),  32'd0);
        check("dump_end_valid", 32'(bus.dump_valid), 32'd0);
        step();

        // Reset in the middle of a dump, then restart
        bus.dump_req = 1'b1;
        step();
        bus.dump_req = 1'b0;
        repeat (10) step();
`ifdef REG_BANK_DUMP_EN
        check("mid_idx10", 32'(bus.dump_idx), 32'd10);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.dump_valid), 32'd0);
        check("mid_rst_busy",  32'(bus.dump_busy),  32'd0);
        check("mid_rst_idx",   32'(bus.dump_idx),   32'd0);
        check("mid_rst_data",  bus.dump_data,       32'd0);
        bus.dump_req = 1'b1;
        step();
        bus.dump_req = 1'b0;
        #1;
`ifdef REG_BANK_DUMP_EN
        check("restart_valid", 32'(bus.dump_valid), 32'd1);
        check("restart_idx",   32'(bus.dump_idx),   32'd0);
`else
        check("restart_valid", 32'(bus.dump_valid), 32'd0);
`endif
        repeat (34) step();
        check("restart_end_busy", 32'(bus.dump_busy), 32'd0);

        // dump_req held high: back-to-back dumps separated by one idle cycle
        bus.read_reg_a = 5'd31; bus.read_reg_b = 5'd29;
        bus.dump_req = 1'b1;
        repeat (70) step();
        bus.dump_req = 1'b0;
        repeat (36) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_wb.md
# reg_bank_wb

Architectural register bank for the multicycle MIPS datapath, sitting directly downstream of the memory-to-register write-back mux. It consumes the selected write-back word, holds the 32 general-purpose registers, and feeds the A/B operand registers through two combinational read ports. It also provides a sequential debug dump engine that streams all 32 registers out, one per cycle, on request.

## Interface
- SP_INDEX, 29: register index loaded with the stack-top value at reset
- SP_RESET_VALUE, 32'd227: reset value of register SP_INDEX; matches the stack-top constant the write-back mux can select
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- reg_write  in  1  write enable from the control unit
- write_reg  in  5  destination register index (rt/rd/31 already selected upstream)
- write_data  in  32  write-back word from the memory-to-register mux
- read_reg_a  in  5  rs index
- read_reg_b  in  5  rt index
- read_data_a  out  32  value of register read_reg_a
- read_data_b  out  32  value of register read_reg_b
- dump_req  in  1  start a full-bank dump; sampled only in IDLE
- dump_busy  out  1  high while the dump engine is in SCAN
- dump_valid  out  1  dump_idx/dump_data carry a valid entry this cycle
- dump_idx  out  5  register index of current dump entry
- dump_data  out  32  value of register dump_idx

## Operation
- Write: on rising edge, if reg_write=1 and write_reg≠0, reg[write_reg] ← write_data. Writes to index 0 discarded; r0 always reads 0.
- Reset has priority over a simultaneous write: after a reset edge, all registers are 0 except reg[SP_INDEX]=SP_RESET_VALUE.
- Read: combinational. Index 0 → 0. If reg_write=1, write_reg≠0, write_reg equals the read index → write_data (write-through bypass). Otherwise stored value. Both ports independent; identical indices return identical data.
- Dump FSM, two states:
  - IDLE: dump_busy=0, dump_valid=0, dump_idx=0, dump_data=0. dump_req=1 at an edge → SCAN, counter=0.
  - SCAN: dump_busy=1, dump_valid=1, dump_idx=counter, dump_data computed by the read-port rule (including bypass). At each edge counter+1; at the edge with counter=31 → IDLE, counter→0 (no wrap into a second pass).
  - dump_req ignored in SCAN. Normal writes and reads proceed unaffected during a dump.
- Reset mid-dump: FSM → IDLE, counter → 0, all dump outputs 0 from the next cycle.

## Timing
- Reset values: read_data_a/b follow the reset array (0, or SP_RESET_VALUE when indexing SP_INDEX); dump_busy=0, dump_valid=0, dump_idx=0, dump_data=0.
- Read latency 0 cycles; written value visible on read ports in the write cycle (bypass) and from the array after the edge.
- Dump: dump_req high at edge N → dump_valid high in cycles N+1..N+32, indices 0..31 in order, exactly 32 consecutive valid cycles, then dump_busy low at N+33.
- Back-to-back dumps: minimum one IDLE cycle between dumps; dump_req held high restarts at the first IDLE edge.

## Configuration
- REG_BANK_DUMP_EN defined: dump FSM and counter built as above.
- Not defined: no FSM or counter logic; dump_busy, dump_valid, dump_idx, dump_data tied to 0; dump_req ignored. Port list unchanged. Register bank behaviour identical in both builds.

## Structure
- Package reg_bank_pkg: REG_COUNT=32, REG_IDX_W=5, DATA_W=32, default SP_INDEX/SP_RESET_VALUE constants, dump state enum {DUMP_IDLE, DUMP_SCAN}.
- One sub-module, reg_dump_fsm: state, 5-bit counter, dump_busy/dump_valid/dump_idx; it drives a third read index into the bank, whose read logic supplies dump_data. Instantiated only under REG_BANK_DUMP_EN.

## Test plan
- Reset, read all indices → r29=227 (0x000000E3), all others 0 on both ports.
- reg_write=1, write_reg=8, write_data=0xDEADBEEF, read_reg_a=8 in same cycle → read_data_a=0xDEADBEEF that cycle and after; write to r0 with 0x1234 → r0 reads 0.
- Assert reset and reg_write (write_reg=29, data=5) same edge → r29=227 afterwards.
- dump_req pulse after writing r1=1, r31=0xFFFFFFFF → 32 consecutive valid cycles, idx 0..31, data 0,1,…,r29=227,…,0xFFFFFFFF; busy low after; dump_req pulse mid-scan ignored.
- Write r5=0x55 during scan cycle with dump_idx=5 → dump_data=0x55 that cycle.
- Reset at dump_idx=10 → dump_valid/busy/idx/data 0 next cycle; new dump_req restarts at idx 0. Build without REG_BANK_DUMP_EN → dump outputs stay 0.
